// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and helpers for the hazard/forwarding unit
//
// Purpose:
//   Forward-select codes, register index width, FSM state encoding and the
//   pipeline tracking entry used by hazard_forward_unit and hazard_track_reg.
//   Select codes drive a 3:1 mux: bit0 picks in1/in2, bit1 overrides to in3.
// Ports: none (package).

package mips_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;  // register file value
   localparam logic [1:0] FWD_WB    = 2'b01;  // result being written back
   localparam logic [1:0] FWD_EXMEM = 2'b10;  // ALU result in EX/MEM

   typedef enum logic [1:0] {
      ST_RUN,
      ST_LDSTALL,
      ST_FREEZE
   } hz_state_t;

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             reg_write;
      logic             mem_read;
   } track_t;

   localparam track_t TRACK_NOP = '0;

   // Register 0 is hard-wired zero, so it never needs forwarding.
   function automatic logic src_match(input logic use_src,
                                      input logic [REG_W-1:0] src,
                                      input track_t e);
      return use_src && e.reg_write && (e.dest == src) && (src != '0);
   endfunction

   // EX/MEM has priority: it holds the youngest value of the register.
   // A producer in WB needs nothing because the register file is write-first.
   function automatic logic [1:0] fwd_code(input logic use_src,
                                           input logic [REG_W-1:0] src,
                                           input track_t ex,
                                           input track_t mem,
                                           input track_t wb);
      if (src_match(use_src, src, ex))
         return FWD_EXMEM;
      else if (src_match(use_src, src, mem))
         return FWD_WB;
      else if (src_match(use_src, src, wb))
         return FWD_RF;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_track_reg.sv
// rtl/hazard_track_reg.sv - one pipeline tracking entry with load/hold/clear
//
// Purpose:
//   Holds {dest, reg_write, mem_read} of the instruction in one pipeline stage.
//   Clear has priority over load; with neither asserted the entry holds.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low (entry becomes NOP)
//   load   in   capture d
//   clear  in   capture NOP
//   d      in   incoming entry
//   q      out  current entry

module hazard_track_reg
   import mips_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   clear,
   input  track_t d,
   output track_t q
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= TRACK_NOP;
      else if (clear)
         q <= TRACK_NOP;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - forwarding select and load-use stall control
//
// Purpose:
//   Tracks destination info for EX/MEM/WB, produces registered ALU operand
//   select codes for the instruction entering EX, and drives stall, bubble
//   and freeze. Optional macro HAZFWD_PERF_EN builds the two perf counters;
//   without it both counter ports are tied to zero.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_rs, id_rt               source registers of the ID instruction
//   id_use_rs, id_use_rt       ID instruction reads rs / rt
//   id_dest, id_reg_write      destination of the ID instruction
//   id_mem_read                ID instruction is a load
//   id_flush                   kill the ID instruction
//   mem_busy                   data memory not ready, freeze the pipeline
//   fwd_a_sel, fwd_b_sel       registered operand selects (valid in EX)
//   stall_if_id, bubble_id_ex  hold PC/IF-ID, load NOP into ID/EX
//   freeze                     hold every pipeline register
//   stall_count, fwd_count     load-use stall cycles / non-zero selects issued

module hazard_forward_unit
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_flush,
   input  logic             mem_busy,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall_if_id,
   output logic             bubble_id_ex,
   output logic             freeze,
   output logic [31:0]      stall_count,
   output logic [31:0]      fwd_count
);

   hz_state_t  state_q, state_d;
   track_t     id_entry, ex_q, mem_q, wb_q;
   logic       load_use;
   logic       advance;
   logic [1:0] fa_d, fb_d;

   assign id_entry = '{dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};

   assign load_use = ex_q.mem_read &&
                     (src_match(id_use_rs, id_rs, ex_q) || src_match(id_use_rt, id_rt, ex_q));

   assign fa_d = fwd_code(id_use_rs, id_rs, ex_q, mem_q, wb_q);
   assign fb_d = fwd_code(id_use_rt, id_rt, ex_q, mem_q, wb_q);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_RUN;
      else
         state_q <= state_d;
   end

   // In LDSTALL the bubble has already emptied EX, so no load-use can exist;
   // the release cycle out of FREEZE behaves exactly like RUN.
   always_comb begin
      state_d      = state_q;
      stall_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      freeze       = 1'b0;
      advance      = 1'b0;
      if (!rst_n) begin
         state_d = ST_RUN;
      end else if (mem_busy) begin
         state_d     = ST_FREEZE;
         freeze      = 1'b1;
         stall_if_id = 1'b1;
      end else begin
         advance = 1'b1;
         case (state_q)
            ST_LDSTALL: begin
               state_d      = ST_RUN;
               bubble_id_ex = id_flush;
            end
            default: begin
               state_d = ST_RUN;
               if (id_flush) begin
                  bubble_id_ex = 1'b1;
               end else if (load_use) begin
                  state_d      = ST_LDSTALL;
                  stall_if_id  = 1'b1;
                  bubble_id_ex = 1'b1;
               end
            end
         endcase
      end
   end

   hazard_track_reg u_ex (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (advance),
      .clear (advance && bubble_id_ex),
      .d     (id_entry),
      .q     (ex_q)
   );

   hazard_track_reg u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (advance),
      .clear (1'b0),
      .d     (ex_q),
      .q     (mem_q)
   );

   hazard_track_reg u_wb (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (advance),
      .clear (1'b0),
      .d     (mem_q),
      .q     (wb_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else if (advance) begin
         fwd_a_sel <= bubble_id_ex ? FWD_RF : fa_d;
         fwd_b_sel <= bubble_id_ex ? FWD_RF : fb_d;
      end
   end

`ifdef HAZFWD_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
         fwd_count   <= '0;
      end else begin
         if (state_q == ST_LDSTALL)
            stall_count <= stall_count + 32'd1;
         if (advance && !bubble_id_ex && ((fa_d != FWD_RF) || (fb_d != FWD_RF)))
            fwd_count <= fwd_count + 32'd1;
      end
   end
`else
   assign stall_count = '0;
   assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed scoreboard bench for hazard_forward_unit

module tb_hazard_forward_unit;
   import mips_pkg::*;

`ifdef HAZFWD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [REG_W-1:0] id_rs, id_rt, id_dest;
   logic             id_use_rs, id_use_rt, id_reg_write, id_mem_read;
   logic             id_flush, mem_busy;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic             stall_if_id, bubble_id_ex, freeze;
   logic [31:0]      stall_count, fwd_count;

   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_dest      (id_dest),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .id_flush     (id_flush),
      .mem_busy     (mem_busy),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall_if_id  (stall_if_id),
      .bubble_id_ex (bubble_id_ex),
      .freeze       (freeze),
      .stall_count  (stall_count),
      .fwd_count    (fwd_count)
   );

   typedef struct {
      string      tag;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_id(input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] dest, input logic rw, input logic mr);
      id_rs        = rs;
      id_use_rs    = urs;
      id_rt        = rt;
      id_use_rt    = urt;
      id_dest      = dest;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   // Inputs are already driven; check combinational outputs this cycle,
   // queue the select expectation, then compare it after the clock edge.
   task automatic step(input string tag, input logic e_st, input logic e_bb,
                       input logic e_fz, input logic [1:0] e_fa, input logic [1:0] e_fb);
      exp_t e;
      #1;
      chk({tag, ".stall"},  {31'd0, stall_if_id},  {31'd0, e_st});
      chk({tag, ".bubble"}, {31'd0, bubble_id_ex}, {31'd0, e_bb});
      chk({tag, ".freeze"}, {31'd0, freeze},       {31'd0, e_fz});
      e.tag = tag;
      e.fa  = e_fa;
      e.fb  = e_fb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, e.fa});
      chk({e.tag, ".fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, e.fb});
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst_n    = 1'b0;
      id_flush = 1'b0;
      mem_busy = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall",  {31'd0, stall_if_id},  32'd0);
      chk("rst.bubble", {31'd0, bubble_id_ex}, 32'd0);
      chk("rst.freeze", {31'd0, freeze},       32'd0);
      chk("rst.fwd_a",  {30'd0, fwd_a_sel},    32'd0);
      chk("rst.fwd_b",  {30'd0, fwd_b_sel},    32'd0);
      chk("rst.stall_count", stall_count, 32'd0);
      chk("rst.fwd_count",   fwd_count,   32'd0);
      rst_n = 1'b1;

      // EX/MEM and WB forwarding
      set_id(1, 1, 2, 1, 3, 1, 0);   step("add3",      0, 0, 0, 2'b00, 2'b00);
      set_id(3, 1, 5, 1, 4, 1, 0);   step("sub_exfwd", 0, 0, 0, 2'b10, 2'b00);
      set_id(0, 0, 0, 0, 0, 0, 0);   step("nop",       0, 0, 0, 2'b00, 2'b00);
      set_id(1, 1, 2, 1, 3, 1, 0);   step("add3b",     0, 0, 0, 2'b00, 2'b00);
      set_id(8, 1, 9, 1, 7, 1, 0);   step("and7",      0, 0, 0, 2'b00, 2'b00);
      set_id(1, 1, 3, 1, 6, 1, 0);   step("or_wbfwd",  0, 0, 0, 2'b00, 2'b01);
      // EX priority over MEM when both hold the same register
      set_id(1, 1, 2, 1, 10, 1, 0);  step("add10",     0, 0, 0, 2'b00, 2'b00);
      set_id(10, 1, 1, 1, 10, 1, 0); step("add10b",    0, 0, 0, 2'b10, 2'b00);
      set_id(10, 1, 10, 1, 11, 1, 0);step("prio",      0, 0, 0, 2'b10, 2'b10);
      // load-use: one stall cycle, then WB forwarding
      set_id(1, 1, 0, 0, 2, 1, 1);   step("lw2",       0, 0, 0, 2'b00, 2'b00);
      set_id(2, 1, 2, 1, 4, 1, 0);   step("lu_stall",  1, 1, 0, 2'b00, 2'b00);
                                     step("lu_retry",  0, 0, 0, 2'b01, 2'b01);
      chk("lu.stall_count", stall_count, PERF ? 32'd1 : 32'd0);
      // register 0 never forwards or stalls
      set_id(1, 1, 2, 1, 0, 1, 0);   step("add0",      0, 0, 0, 2'b00, 2'b00);
      set_id(0, 1, 0, 1, 12, 1, 0);  step("use0",      0, 0, 0, 2'b00, 2'b00);
      set_id(1, 1, 0, 0, 0, 1, 1);   step("lw0",       0, 0, 0, 2'b00, 2'b00);
      set_id(0, 1, 0, 1, 13, 1, 0);  step("use0_lw",   0, 0, 0, 2'b00, 2'b00);
      // freeze for 3 cycles in the middle of a load-use hazard
      set_id(13, 1, 0, 0, 8, 1, 1);  step("lw8",       0, 0, 0, 2'b10, 2'b00);
      set_id(8, 1, 1, 1, 9, 1, 0);
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++)
         step($sformatf("frz%0d", i), 1, 0, 1, 2'b10, 2'b00);
      mem_busy = 1'b0;
      step("frz_lu",   1, 1, 0, 2'b00, 2'b00);
      step("frz_retry", 0, 0, 0, 2'b01, 2'b00);
      chk("frz.stall_count", stall_count, PERF ? 32'd2 : 32'd0);
      // flush wins over load-use
      set_id(1, 1, 0, 0, 20, 1, 1);  step("lw20",      0, 0, 0, 2'b00, 2'b00);
      set_id(20, 1, 20, 1, 21, 1, 0);
      id_flush = 1'b1;               step("flush_lu",  0, 1, 0, 2'b00, 2'b00);
      id_flush = 1'b0;
      set_id(20, 1, 1, 1, 22, 1, 0); step("post_flush",0, 0, 0, 2'b01, 2'b00);
      chk("flush.stall_count", stall_count, PERF ? 32'd2 : 32'd0);
      set_id(22, 1, 22, 1, 23, 1, 0);step("sub23",     0, 0, 0, 2'b10, 2'b10);
      chk("pre_rst.fwd_count", fwd_count, PERF ? 32'd9 : 32'd0);
      // mid-stream reset drops everything in flight
      rst_n = 1'b0;
      set_id(23, 1, 23, 1, 25, 1, 0);step("mid_rst",   0, 0, 0, 2'b00, 2'b00);
      chk("mid_rst.stall_count", stall_count, 32'd0);
      chk("mid_rst.fwd_count",   fwd_count,   32'd0);
      rst_n = 1'b1;
      set_id(23, 1, 23, 1, 26, 1, 0);step("after_rst", 0, 0, 0, 2'b00, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
